dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 reqN_valid_i (N=1,2)  in  1  slot N memory request present.
REQ-005 reqN_we_i  in  1  slot N store (1) / load (0).
REQ-006 reqN_pc_i  in  32  slot N instruction PC, age key.
REQ-007 reqN_addr_i  in  32  slot N byte address.
REQ-008 reqN_sel_i  in  4  slot N byte lane enables.
REQ-009 reqN_wdata_i  in  32  slot N store data.
REQ-010 req_ready_o  out  1  arbiter accepts a request pair this cycle.
REQ-011 resp_valid_o  out  1  one-cycle pulse, both response words valid.
REQ-012 respN_rdata_o  out  32  slot N load data.
REQ-013 ram_ce_o / ram_we_o  out  1 / 1  single RAM port enables.
REQ-014 ram_addr_o / ram_sel_o / ram_wdata_o  out  32 / 4 / 32  RAM port address, lanes, data.
REQ-015 ram_rdata_i  in  32  RAM read data, registered, one-cycle latency.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE_FIRST, ISSUE_SECOND, DRAIN, RESP.
REQ-017 req_ready_o SHALL be 1 only in IDLE.
REQ-018 Acceptance: IDLE and (req1_valid_i or req2_valid_i) -> both slots latched (invalid slot latched as empty), respN_rdata_o cleared to 0, go ISSUE_FIRST.
REQ-019 Order: both valid -> lower PC issued first; equal PC -> slot 1 first; one valid -> that slot only.
REQ-020 ISSUE_FIRST: drive first slot onto RAM port (ram_ce_o=1, ram_we_o=slot we); next state ISSUE_SECOND if second slot present, else DRAIN.
REQ-021 ISSUE_SECOND: drive second slot onto RAM port; capture ram_rdata_i into first slot's resp register; next DRAIN.
REQ-022 DRAIN: RAM port idle; capture ram_rdata_i into last-issued slot's resp register; next RESP.
REQ-023 RESP: resp_valid_o=1 for exactly one cycle; next IDLE.
REQ-024 Latency: single request accepted cycle 0 -> resp_valid_o cycle 3; pair -> cycle 4.
REQ-025 Store slots and empty slots SHALL return respN_rdata_o=0; load data captured for loads only.
REQ-026 Same-word hazards resolved by order only: older store then younger load returns new data; two stores leave younger data; older load before younger store returns old data.
REQ-027 Outside ISSUE_* states ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_wdata_o SHALL all be 0.
REQ-028 respN_rdata_o SHALL hold their value from RESP until next acceptance.
REQ-029 Request inputs SHALL be sampled only at acceptance; changes afterward have no effect.

Reset
REQ-030 On rst: state IDLE, req_ready_o=0 while rst high, resp_valid_o=0, respN_rdata_o=0, all ram_* outputs 0, slot buffers empty.
REQ-031 Reset mid-operation SHALL abort immediately; any unissued store is dropped, no response produced.
REQ-032 First acceptance possible on the first rising edge after rst deasserts.

Structure
REQ-033 Bus widths and FSM state encodings SHALL live in the shared defines file (DataBus, DataAddrBus, InstAddrBus, ARB_* states).
REQ-034 A sub-module mem_req_buf (one latched request: valid, we, pc, addr, sel, wdata) SHALL be instantiated twice.
REQ-035 Order decision SHALL be computed once at acceptance and registered.

Verification
REQ-036 Single load slot 2, addr 0x10, RAM holds 0xDEADBEEF -> ram_ce_o cycle 1, resp_valid_o cycle 3, resp2_rdata_o=0xDEADBEEF, resp1_rdata_o=0.
REQ-037 Slot1 store pc 0x1C04 addr 0x20 data 0x11111111; slot2 store pc 0x1C00 addr 0x20 data 0x22222222 -> slot 2 issued first, final word 0x11111111, resp cycle 4.
REQ-038 Slot1 store pc 0x100 addr 0x40 data 0xA5A5A5A5 sel 0xF; slot2 load pc 0x104 addr 0x40 -> resp2_rdata_o=0xA5A5A5A5.
REQ-039 Slot1 load pc 0x200, slot2 store pc 0x200 same addr, old 0x0, new 0x5 -> slot 1 first, resp1_rdata_o=0x0, RAM ends 0x5.
REQ-040 Byte store sel 0x2 data 0x0000AB00 to word 0x12345678 -> following load returns 0x1234AB78.
REQ-041 rst asserted during ISSUE_SECOND of store pair -> ram_* 0 immediately, second store never written, resp_valid_o stays 0, req_ready_o=1 after release.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared widths, FSM states and request record for dmem_arbiter
package dmem_arbiter_pkg;

    localparam int DataBus     = 32;
    localparam int DataAddrBus = 32;
    localparam int InstAddrBus = 32;
    localparam int SelBus      = 4;

    typedef enum logic [2:0] {
        ARB_IDLE         = 3'd0,
        ARB_ISSUE_FIRST  = 3'd1,
        ARB_ISSUE_SECOND = 3'd2,
        ARB_DRAIN        = 3'd3,
        ARB_RESP         = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [InstAddrBus-1:0] pc;
        logic [DataAddrBus-1:0] addr;
        logic [SelBus-1:0]      sel;
        logic [DataBus-1:0]     wdata;
    } mem_req_t;

    // Slot 2 goes first only when it is present and strictly older (lower PC) or alone.
    function automatic logic slot2_goes_first(input logic v1, input logic v2,
                                              input logic [InstAddrBus-1:0] pc1,
                                              input logic [InstAddrBus-1:0] pc2);
        return v2 && (!v1 || (pc2 < pc1));
    endfunction

endpackage

// File: rtl/dmem_arbiter_mem_req_buf.sv
// rtl/dmem_arbiter_mem_req_buf.sv - one latched memory request slot
module mem_req_buf
    import dmem_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  mem_req_t i_req,
    output mem_req_t o_req
);

    mem_req_t r_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req <= '0;
        end else if (i_load) begin
            r_req <= i_req;
        end
    end

    assign o_req = r_req;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - serialises a pair of data memory requests onto one RAM port in PC order
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req1_valid_i,
    input  logic                   req1_we_i,
    input  logic [InstAddrBus-1:0] req1_pc_i,
    input  logic [DataAddrBus-1:0] req1_addr_i,
    input  logic [SelBus-1:0]      req1_sel_i,
    input  logic [DataBus-1:0]     req1_wdata_i,
    input  logic                   req2_valid_i,
    input  logic                   req2_we_i,
    input  logic [InstAddrBus-1:0] req2_pc_i,
    input  logic [DataAddrBus-1:0] req2_addr_i,
    input  logic [SelBus-1:0]      req2_sel_i,
    input  logic [DataBus-1:0]     req2_wdata_i,
    output logic                   req_ready_o,
    output logic                   resp_valid_o,
    output logic [DataBus-1:0]     resp1_rdata_o,
    output logic [DataBus-1:0]     resp2_rdata_o,
    output logic                   ram_ce_o,
    output logic                   ram_we_o,
    output logic [DataAddrBus-1:0] ram_addr_o,
    output logic [SelBus-1:0]      ram_sel_o,
    output logic [DataBus-1:0]     ram_wdata_o,
    input  logic [DataBus-1:0]     ram_rdata_i
);

    arb_state_e         r_state;
    arb_state_e         w_next;
    logic               r_slot2_first;
    logic [DataBus-1:0] r_resp1;
    logic [DataBus-1:0] r_resp2;
    logic               w_accept;
    logic               w_last_is_2;
    logic               w_last_we;
    mem_req_t           w_in1;
    mem_req_t           w_in2;
    mem_req_t           w_buf1;
    mem_req_t           w_buf2;
    mem_req_t           w_first;
    mem_req_t           w_second;
    logic               w_unused_pc;

    assign w_accept = (r_state == ARB_IDLE) && (req1_valid_i || req2_valid_i);

    // An absent slot is latched as all-zero so it can never reach the RAM port.
    always_comb begin
        w_in1 = '0;
        w_in2 = '0;
        if (req1_valid_i) begin
            w_in1 = {1'b1, req1_we_i, req1_pc_i, req1_addr_i, req1_sel_i, req1_wdata_i};
        end
        if (req2_valid_i) begin
            w_in2 = {1'b1, req2_we_i, req2_pc_i, req2_addr_i, req2_sel_i, req2_wdata_i};
        end
    end

    mem_req_buf u_buf1 (.clk(clk), .rst(rst), .i_load(w_accept), .i_req(w_in1), .o_req(w_buf1));
    mem_req_buf u_buf2 (.clk(clk), .rst(rst), .i_load(w_accept), .i_req(w_in2), .o_req(w_buf2));

    // Latched PCs stay in the slots for observability; the issue order is already registered.
    assign w_unused_pc = ^{w_buf1.pc, w_buf2.pc};

    assign w_first     = r_slot2_first ? w_buf2 : w_buf1;
    assign w_second    = r_slot2_first ? w_buf1 : w_buf2;
    assign w_last_is_2 = w_second.valid ? !r_slot2_first : r_slot2_first;
    assign w_last_we   = w_second.valid ? w_second.we : w_first.we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            r_slot2_first <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_slot2_first <= slot2_goes_first(req1_valid_i, req2_valid_i, req1_pc_i, req2_pc_i);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ARB_IDLE:         if (w_accept) w_next = ARB_ISSUE_FIRST;
            ARB_ISSUE_FIRST:  w_next = w_second.valid ? ARB_ISSUE_SECOND : ARB_DRAIN;
            ARB_ISSUE_SECOND: w_next = ARB_DRAIN;
            ARB_DRAIN:        w_next = ARB_RESP;
            ARB_RESP:         w_next = ARB_IDLE;
            default:          w_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        ram_ce_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = '0;
        ram_sel_o    = '0;
        ram_wdata_o  = '0;
        case (r_state)
            ARB_IDLE: req_ready_o = !rst;
            ARB_ISSUE_FIRST: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = w_first.we;
                ram_addr_o  = w_first.addr;
                ram_sel_o   = w_first.sel;
                ram_wdata_o = w_first.wdata;
            end
            ARB_ISSUE_SECOND: begin
                ram_ce_o    = 1'b1;
                ram_we_o    = w_second.we;
                ram_addr_o  = w_second.addr;
                ram_sel_o   = w_second.sel;
                ram_wdata_o = w_second.wdata;
            end
            ARB_RESP: resp_valid_o = 1'b1;
            default: ;
        endcase
    end

    // RAM data lags its issue by one cycle, so each capture targets the previously issued slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp1 <= '0;
            r_resp2 <= '0;
        end else if (w_accept) begin
            r_resp1 <= '0;
            r_resp2 <= '0;
        end else if (r_state == ARB_ISSUE_SECOND && !w_first.we) begin
            if (r_slot2_first) r_resp2 <= ram_rdata_i;
            else               r_resp1 <= ram_rdata_i;
        end else if (r_state == ARB_DRAIN && !w_last_we) begin
            if (w_last_is_2) r_resp2 <= ram_rdata_i;
            else             r_resp1 <= ram_rdata_i;
        end
    end

    assign resp1_rdata_o = r_resp1;
    assign resp2_rdata_o = r_resp2;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    typedef struct {
        logic        v;
        logic        we;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        req_t        a;
        req_t        b;
        logic        pre_en;
        logic [31:0] pre_addr;
        logic [31:0] pre_data;
        logic [31:0] exp_r1;
        logic [31:0] exp_r2;
        int          exp_lat;
        logic        exp_fwe;
        logic [31:0] exp_fwd;
        logic [31:0] chk_addr;
        logic [31:0] exp_word;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req1_valid_i = 0, req1_we_i = 0, req2_valid_i = 0, req2_we_i = 0;
    logic [31:0] req1_pc_i = 0, req1_addr_i = 0, req1_wdata_i = 0;
    logic [31:0] req2_pc_i = 0, req2_addr_i = 0, req2_wdata_i = 0;
    logic [3:0]  req1_sel_i = 0, req2_sel_i = 0;
    logic        req_ready_o, resp_valid_o, ram_ce_o, ram_we_o;
    logic [31:0] resp1_rdata_o, resp2_rdata_o, ram_addr_o, ram_wdata_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_rdata_i = 0;

    logic        mem_clr = 1'b1;
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 0;
    logic [31:0] pre_data = 0;
    logic [31:0] ram [64];
    logic [31:0] ref_mem [64];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req1_valid_i(req1_valid_i), .req1_we_i(req1_we_i), .req1_pc_i(req1_pc_i),
        .req1_addr_i(req1_addr_i), .req1_sel_i(req1_sel_i), .req1_wdata_i(req1_wdata_i),
        .req2_valid_i(req2_valid_i), .req2_we_i(req2_we_i), .req2_pc_i(req2_pc_i),
        .req2_addr_i(req2_addr_i), .req2_sel_i(req2_sel_i), .req2_wdata_i(req2_wdata_i),
        .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o),
        .resp1_rdata_o(resp1_rdata_o), .resp2_rdata_o(resp2_rdata_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    // Word-addressed RAM with registered read data and byte-lane writes.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) ram[i] <= '0;
        end else if (pre_we) begin
            ram[pre_idx] <= pre_data;
        end else if (ram_ce_o) begin
            if (ram_we_o) begin
                for (int l = 0; l < 4; l++)
                    if (ram_sel_o[l]) ram[ram_addr_o[7:2]][l*8 +: 8] <= ram_wdata_o[l*8 +: 8];
            end else begin
                ram_rdata_i <= ram[ram_addr_o[7:2]];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (sel[l]) r[l*8 +: 8] = d[l*8 +: 8];
        return r;
    endfunction

    task automatic drive(input req_t a, input req_t b);
        req1_valid_i = a.v; req1_we_i = a.we; req1_pc_i = a.pc;
        req1_addr_i = a.addr; req1_sel_i = a.sel; req1_wdata_i = a.wd;
        req2_valid_i = b.v; req2_we_i = b.we; req2_pc_i = b.pc;
        req2_addr_i = b.addr; req2_sel_i = b.sel; req2_wdata_i = b.wd;
    endtask

    function automatic req_t rand_req(input logic v);
        req_t r;
        r.v = v; r.we = 1'($urandom_range(0, 1));
        r.pc = 32'h400 + 32'($urandom_range(0, 3)) * 4;
        r.addr = 32'h80 + 32'($urandom_range(0, 3)) * 4;
        r.sel = 4'($urandom); r.wd = $urandom;
        return r;
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pre_idx = addr[7:2]; pre_data = data; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[addr[7:2]] = data;
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) bad++;
        check(name, 32'(bad), 32'd0);
    endtask

    // Starts and ends at a falling edge with the DUT idle.
    task automatic run_txn(input req_t a, input req_t b, output logic [31:0] o_r1,
                           output logic [31:0] o_r2, output int o_lat,
                           output logic o_fwe, output logic [31:0] o_fwd);
        req_t        s[2];
        int          ord[$];
        logic [31:0] e1, e2;
        int          ce_cnt;
        logic        leak;
        req_t        iss[2];
        req_t        zero;
        zero = '{default: '0};
        s[0] = a; s[1] = b;
        if (a.v && b.v) begin
            if (b.pc < a.pc) begin ord.push_back(1); ord.push_back(0); end
            else begin ord.push_back(0); ord.push_back(1); end
        end else if (a.v) ord.push_back(0);
        else ord.push_back(1);
        e1 = 0; e2 = 0;
        foreach (ord[k]) begin
            req_t r;
            r = s[ord[k]];
            if (r.we) ref_mem[r.addr[7:2]] = merge(ref_mem[r.addr[7:2]], r.wd, r.sel);
            else if (ord[k] == 0) e1 = ref_mem[r.addr[7:2]];
            else e2 = ref_mem[r.addr[7:2]];
        end

        check("ready_in_idle", 32'(req_ready_o), 32'd1);
        drive(a, b);
        o_lat = 0; ce_cnt = 0; leak = 0; iss[0] = zero; iss[1] = zero;
        o_r1 = 0; o_r2 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_ce_o) begin
                if (ce_cnt < 2) iss[ce_cnt] = '{1'b1, ram_we_o, 32'd0, ram_addr_o, ram_sel_o, ram_wdata_o};
                ce_cnt++;
                if (c != ce_cnt) leak = 1;
            end else if (ram_we_o || ram_addr_o != 0 || ram_sel_o != 0 || ram_wdata_o != 0) begin
                leak = 1;
            end
            if (c == 1) drive(rand_req(1'b1), rand_req(1'b1));
            if (c == 2) drive(zero, zero);
            if (resp_valid_o) begin
                o_lat = c; o_r1 = resp1_rdata_o; o_r2 = resp2_rdata_o;
                break;
            end
        end
        o_fwe = iss[0].we; o_fwd = iss[0].wd;

        check("latency", 32'(o_lat), 32'(2 + ord.size()));
        check("resp1", o_r1, e1);
        check("resp2", o_r2, e2);
        check("issue_count", 32'(ce_cnt), 32'(ord.size()));
        check("ram_idle_zero", 32'(leak), 32'd0);
        foreach (ord[k]) begin
            if (k < 2) begin
                check("issue_addr", iss[k].addr, s[ord[k]].addr);
                check("issue_we", 32'(iss[k].we), 32'(s[ord[k]].we));
                check("issue_sel", 32'(iss[k].sel), 32'(s[ord[k]].sel));
                if (s[ord[k]].we) check("issue_wdata", iss[k].wd, s[ord[k]].wd);
            end
        end
        @(negedge clk);
        check("resp_pulse_once", 32'(resp_valid_o), 32'd0);
        check("resp1_hold", resp1_rdata_o, e1);
        check("resp2_hold", resp2_rdata_o, e2);
        check_mem("ram_contents");
    endtask

    function automatic req_t mk(input logic v, input logic we, input logic [31:0] pc,
                                input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] wd);
        req_t r;
        r.v = v; r.we = we; r.pc = pc; r.addr = addr; r.sel = sel; r.wd = wd;
        return r;
    endfunction

    initial begin
        vec_t        vecs[6];
        logic [31:0] r1, r2, fwd;
        int          lat;
        logic        fwe;
        req_t        none;
        none = mk(0, 0, 0, 0, 0, 0);

        vecs[0] = '{none, mk(1, 0, 32'h0, 32'h10, 4'hF, 32'h0), 1'b1, 32'h10, 32'hDEADBEEF,
                    32'h0, 32'hDEADBEEF, 3, 1'b0, 32'h0, 32'h10, 32'hDEADBEEF};
        vecs[1] = '{mk(1, 1, 32'h1C04, 32'h20, 4'hF, 32'h11111111),
                    mk(1, 1, 32'h1C00, 32'h20, 4'hF, 32'h22222222), 1'b0, 32'h0, 32'h0,
                    32'h0, 32'h0, 4, 1'b1, 32'h22222222, 32'h20, 32'h11111111};
        vecs[2] = '{mk(1, 1, 32'h100, 32'h40, 4'hF, 32'hA5A5A5A5),
                    mk(1, 0, 32'h104, 32'h40, 4'hF, 32'h0), 1'b0, 32'h0, 32'h0,
                    32'h0, 32'hA5A5A5A5, 4, 1'b1, 32'hA5A5A5A5, 32'h40, 32'hA5A5A5A5};
        vecs[3] = '{mk(1, 0, 32'h200, 32'h30, 4'hF, 32'h0),
                    mk(1, 1, 32'h200, 32'h30, 4'hF, 32'h5), 1'b1, 32'h30, 32'h0,
                    32'h0, 32'h0, 4, 1'b0, 32'h0, 32'h30, 32'h5};
        vecs[4] = '{mk(1, 1, 32'h300, 32'h50, 4'h2, 32'h0000AB00),
                    mk(1, 0, 32'h304, 32'h50, 4'hF, 32'h0), 1'b1, 32'h50, 32'h12345678,
                    32'h0, 32'h1234AB78, 4, 1'b1, 32'h0000AB00, 32'h50, 32'h1234AB78};
        vecs[5] = '{mk(1, 0, 32'h500, 32'h44, 4'hF, 32'h0), none, 1'b1, 32'h44, 32'hCAFEF00D,
                    32'hCAFEF00D, 32'h0, 3, 1'b0, 32'h0, 32'h44, 32'hCAFEF00D};

        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_ram_ce", 32'(ram_ce_o), 32'd0);
        check("rst_resp1", resp1_rdata_o, 32'd0);
        check("rst_resp2", resp2_rdata_o, 32'd0);
        mem_clr = 1'b0;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].pre_en) preload(vecs[v].pre_addr, vecs[v].pre_data);
            run_txn(vecs[v].a, vecs[v].b, r1, r2, lat, fwe, fwd);
            check($sformatf("vec%0d_r1", v), r1, vecs[v].exp_r1);
            check($sformatf("vec%0d_r2", v), r2, vecs[v].exp_r2);
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d_first_we", v), 32'(fwe), 32'(vecs[v].exp_fwe));
            check($sformatf("vec%0d_first_wd", v), fwd, vecs[v].exp_fwd);
            check($sformatf("vec%0d_word", v), ram[vecs[v].chk_addr[7:2]], vecs[v].exp_word);
        end

        @(negedge clk);
        check("no_valid_stays_idle", 32'(req_ready_o), 32'd1);
        check("no_valid_ram_ce", 32'(ram_ce_o), 32'd0);

        // Reset while the second store of a pair is on the RAM port.
        drive(mk(1, 1, 32'h10, 32'h60, 4'hF, 32'h77), mk(1, 1, 32'h14, 32'h64, 4'hF, 32'h88));
        @(negedge clk);
        drive(none, none);
        @(negedge clk);
        check("mid_rst_issue_second", 32'(ram_ce_o) + 32'(ram_we_o), 32'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_ram_ce", 32'(ram_ce_o), 32'd0);
        check("mid_rst_ram_bus", ram_addr_o | ram_wdata_o | 32'(ram_sel_o) | 32'(ram_we_o), 32'd0);
        check("mid_rst_ready", 32'(req_ready_o), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("mid_rst_no_resp", 32'(resp_valid_o), 32'd0);
        end
        rst = 1'b0;
        #1;
        check("mid_rst_ready_after", 32'(req_ready_o), 32'd1);
        check("mid_rst_second_dropped", ram[6'h19], 32'h0);
        check("mid_rst_first_written", ram[6'h18], 32'h77);
        ref_mem[6'h18] = 32'h77;
        @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            req_t a, b;
            int   pick;
            pick = $urandom_range(0, 2);
            a = rand_req(pick != 2);
            b = rand_req(pick != 1);
            run_txn(a, b, r1, r2, lat, fwe, fwd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
